// File: rtl/dsa_pkg.sv
// Shared types and widths for the output-image readback path.
package dsa_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN,
        RD_FIN
    } rd_state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry registered FIFO; the head entry drives the stream outputs directly.
module stream_skid_fifo
    import dsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [PIX_W-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [PIX_W-1:0] head_data,
    output logic [1:0]       occ
);

    logic [PIX_W-1:0] tail_data;
    logic [1:0]       occ_next;

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (pop && !push) begin
            occ_next = occ - 2'd1;
        end
    end

    // Head only changes on pop or on a push into an empty FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            head_valid <= 1'b0;
            head_data  <= '0;
            tail_data  <= '0;
        end else begin
            occ        <= occ_next;
            head_valid <= (occ_next != 2'd0);
            if (pop) begin
                head_data <= (push && occ == 2'd1) ? push_data : tail_data;
                if (push && occ == 2'd2) begin
                    tail_data <= push_data;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head_data <= push_data;
                end else begin
                    tail_data <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/out_stream_reader.sv
// Scans the output image BRAM from address 0 and streams pixels on a valid/ready
// byte interface, accumulating a transfer count and an additive checksum.
module out_stream_reader
    import dsa_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      i_out_w,
    input  logic [15:0]      i_out_h,
    output logic             busy,
    output logic             done,
    output logic             o_err_size,
    output logic [AW-1:0]    mem_raddr,
    input  logic [PIX_W-1:0] mem_rdata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_checksum
);

    localparam logic [CNT_W-1:0] MAX_PIX = CNT_W'(1) << AW;

    rd_state_e        state;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] req_total;
    logic [AW-1:0]    ptr;
    logic             rd_pend;
    logic             cap_pend;
    logic [1:0]       occ;
    logic             pop_c;
    logic             push_c;
    logic             issue_c;
    logic             cap_next;
    logic [1:0]       occ_next;
    logic [CNT_W-1:0] count_next;

    stream_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_data  (mem_rdata),
        .pop        (pop_c),
        .head_valid (m_valid),
        .head_data  (m_data),
        .occ        (occ)
    );

    // rd_pend: address on the bus, not yet sampled by the BRAM.
    // cap_pend: data sitting in the BRAM output register. That register holds
    // while mem_raddr holds, so a capture can wait there until the FIFO has room;
    // a new read is only issued when the pending capture is guaranteed a slot.
    always_comb begin
        req_total  = CNT_W'(i_out_w) * CNT_W'(i_out_h);
        pop_c      = m_valid & m_ready;
        push_c     = cap_pend && ((occ - 2'(pop_c)) != 2'd2);
        occ_next   = occ - 2'(pop_c) + 2'(push_c);
        cap_next   = rd_pend | (cap_pend & ~push_c);
        issue_c    = (state == RD_RUN) && (occ_next != 2'd2);
        count_next = o_count + CNT_W'(pop_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RD_IDLE;
            total      <= '0;
            ptr        <= '0;
            rd_pend    <= 1'b0;
            cap_pend   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            o_err_size <= 1'b0;
            mem_raddr  <= '0;
            m_last     <= 1'b0;
            o_count    <= '0;
            o_checksum <= '0;
        end else begin
            done     <= 1'b0;
            rd_pend  <= 1'b0;
            cap_pend <= cap_next;
            m_last   <= (occ_next != 2'd0) && (count_next == total - CNT_W'(1));

            if (pop_c) begin
                o_count    <= count_next;
                o_checksum <= o_checksum + CNT_W'(m_data);
            end

            case (state)
                RD_IDLE: begin
                    if (start) begin
                        total      <= req_total;
                        o_count    <= '0;
                        o_checksum <= '0;
                        o_err_size <= 1'b0;
                        if (req_total == '0 || req_total > MAX_PIX) begin
                            o_err_size <= 1'b1;
                            done       <= 1'b1;
                            state      <= RD_FIN;
                        end else begin
                            // First read goes out on the accepting edge.
                            mem_raddr <= '0;
                            ptr       <= AW'(1);
                            rd_pend   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= (req_total == CNT_W'(1)) ? RD_DRAIN : RD_RUN;
                        end
                    end
                end
                RD_RUN: begin
                    if (issue_c) begin
                        mem_raddr <= ptr;
                        ptr       <= ptr + AW'(1);
                        rd_pend   <= 1'b1;
                        if (CNT_W'(ptr) == total - CNT_W'(1)) begin
                            state <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (occ_next == 2'd0 && !cap_next) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= RD_FIN;
                    end
                end
                RD_FIN: begin
                    state <= RD_IDLE;
                end
                default: begin
                    state <= RD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_out_stream_reader.sv
// Directed bench for out_stream_reader with a registered BRAM model and stream monitor.
module tb_out_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] i_out_w = '0;
    logic [15:0] i_out_h = '0;
    logic        busy;
    logic        done;
    logic        o_err_size;
    logic [11:0] mem_raddr;
    logic [7:0]  mem_rdata = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic [31:0] o_count;
    logic [31:0] o_checksum;

    logic [7:0]  mem [0:4095];
    logic [8:0]  q [$];
    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    int          first_edge = -1;
    int          last_edge = -1;
    int          done_cyc = -1;
    int          stall_events = 0;
    bit          any_valid = 1'b0;
    bit          stall_armed = 1'b0;
    logic [8:0]  stall_word = '0;
    bit          ready_mode = 1'b0;
    logic [3:0]  pat = 4'b1001;
    int          ridx = 0;

    out_stream_reader #(.AW(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .i_out_w    (i_out_w),
        .i_out_h    (i_out_h),
        .busy       (busy),
        .done       (done),
        .o_err_size (o_err_size),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .o_count    (o_count),
        .o_checksum (o_checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: records transfers and checks hold behaviour during stalls.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_valid) any_valid = 1'b1;
        if (stall_armed) begin
            stall_events++;
            check("stall_valid", 32'(m_valid), 1);
            check("stall_word", 32'({m_last, m_data}), 32'(stall_word));
        end
        stall_armed = m_valid && !m_ready;
        stall_word  = {m_last, m_data};
        if (m_valid && m_ready) begin
            if (q.size() == 0) first_edge = cyc;
            q.push_back({m_last, m_data});
            if (m_last) last_edge = cyc;
        end
    end

    always @(negedge clk) begin
        if (ready_mode) begin
            m_ready = pat[ridx[1:0]];
            ridx = (ridx + 1) % 4;
        end else begin
            m_ready = 1'b1;
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        done_cyc = -1;
        while (n < budget) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            n++;
        end
        check("done_seen", 32'(done_cyc >= 0), 1);
    endtask

    task automatic check_seq(input string tag, input int n, input bit ramp);
        int bad;
        bad = 0;
        check({tag, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < q.size(); i++) begin
            logic [8:0] e;
            e = {(i == n - 1), ramp ? 8'(i) : 8'hFF};
            if (q[i] !== e) bad++;
        end
        check({tag, "_seq"}, 32'(bad), 0);
    endtask

    task automatic fill_mem(input bit ramp);
        for (int a = 0; a < 4096; a++) mem[a] = ramp ? 8'(a) : 8'hFF;
    endtask

    initial begin
        fill_mem(1'b1);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_raddr", 32'(mem_raddr), 0);
        check("rst_count", o_count, 0);
        check("rst_err", 32'(o_err_size), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4 ramp, ready held high: latency, order, m_last, done timing
        q.delete();
        i_out_w = 16'd4; i_out_h = 16'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("lat_busy", 32'(busy), 1);
        check("lat_addr0", 32'(mem_raddr), 0);
        check("lat_valid_e0", 32'(m_valid), 0);
        @(negedge clk);
        check("lat_addr1", 32'(mem_raddr), 1);
        check("lat_valid_e1", 32'(m_valid), 0);
        @(negedge clk);
        check("lat_valid_e2", 32'(m_valid), 1);
        check("lat_data0", 32'(m_data), 0);
        wait_done(200);
        check_seq("s4x4", 16, 1'b1);
        check("s4x4_done_lat", 32'(done_cyc), 32'(last_edge + 1));
        check("s4x4_thruput", 32'(last_edge - first_edge), 15);
        check("s4x4_count", o_count, 16);
        check("s4x4_csum", o_checksum, 120);
        check("s4x4_busy_done", 32'(busy), 0);
        check("s4x4_last_addr", 32'(mem_raddr), 15);

        // zero-area request
        ready_mode = 1'b1; ridx = 0;
        @(negedge clk);
        any_valid = 1'b0;
        i_out_w = 16'd0; i_out_h = 16'd64; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("e0_done", 32'(done), 1);
        check("e0_err", 32'(o_err_size), 1);
        check("e0_busy", 32'(busy), 0);
        check("e0_count", o_count, 0);
        repeat (4) @(negedge clk);
        check("e0_no_valid", 32'(any_valid), 0);
        check("e0_no_read", 32'(mem_raddr), 15);
        check("e0_err_sticky", 32'(o_err_size), 1);

        // 65x64 too large; a start in the done cycle is ignored, the next one taken
        i_out_w = 16'd65; i_out_h = 16'd64; start = 1'b1;
        @(negedge clk);
        check("e1_done", 32'(done), 1);
        check("e1_err", 32'(o_err_size), 1);
        q.delete();
        i_out_w = 16'd4; i_out_h = 16'd4;
        @(negedge clk);
        check("ign_busy", 32'(busy), 0);
        check("ign_err", 32'(o_err_size), 1);
        check("e1_no_valid", 32'(any_valid), 0);
        @(negedge clk); start = 1'b0;
        check("acc_busy", 32'(busy), 1);
        check("acc_err_clr", 32'(o_err_size), 0);
        stall_events = 0;
        wait_done(400);
        check_seq("stall", 16, 1'b1);
        check("stall_count", o_count, 16);
        check("stall_csum", o_checksum, 120);
        check("stall_seen", 32'(stall_events > 0), 1);
        check("stall_done_lat", 32'(done_cyc), 32'(last_edge + 1));
        ready_mode = 1'b0;

        // 64x64 all 0xFF with an extra start pulsed mid-scan
        fill_mem(1'b0);
        @(negedge clk);
        q.delete();
        i_out_w = 16'd64; i_out_h = 16'd64; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        i_out_w = 16'd4; i_out_h = 16'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(6000);
        check_seq("full", 4096, 1'b0);
        check("full_count", o_count, 4096);
        check("full_csum", o_checksum, 32'h000F_F000);
        check("full_last_addr", 32'(mem_raddr), 4095);
        check("full_err", 32'(o_err_size), 0);
        check("full_done_lat", 32'(done_cyc), 32'(last_edge + 1));

        // reset at pixel 7, then a fresh scan from address 0
        fill_mem(1'b1);
        @(negedge clk);
        i_out_w = 16'd4; i_out_h = 16'd4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        begin
            int n;
            n = 0;
            while (o_count != 32'd7 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("rst7_reached", o_count, 7);
        end
        rst_n = 1'b0;
        #1;
        check("rst7_busy", 32'(busy), 0);
        check("rst7_valid", 32'(m_valid), 0);
        check("rst7_count", o_count, 0);
        check("rst7_csum", o_checksum, 0);
        check("rst7_raddr", 32'(mem_raddr), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        q.delete();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("re_addr0", 32'(mem_raddr), 0);
        wait_done(200);
        check_seq("rescan", 16, 1'b1);
        check("rescan_csum", o_checksum, 120);
        check("rescan_count", o_count, 16);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/out_stream_reader.md
# out_stream_reader

Sequential reader for the output image BRAM that the bilinear core fills. After a start pulse it scans `out_w*out_h` pixels from address 0 upward and presents them in order on a valid/ready byte stream. It accumulates a pixel count and a 32-bit additive checksum over the pixels it delivers. It sits between the output `onchip_mem_dp` read port and any downstream consumer, such as a readback path or a verification monitor.

## Interface
- `AW`, 12, BRAM address width; capacity is 2**AW pixels.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  single-cycle start request; ignored while `busy`.
- `i_out_w`  in  16  output image width in pixels, sampled on an accepted `start`.
- `i_out_h`  in  16  output image height in pixels, sampled on an accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `o_err_size`  out  1  sticky until the next accepted start; the requested size was illegal.
- `mem_raddr`  out  AW  BRAM read address; BRAM returns registered `mem_rdata` one cycle later.
- `mem_rdata`  in  8  BRAM read data.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream ready; a transfer occurs when `m_valid & m_ready`.
- `m_data`  out  8  pixel value.
- `m_last`  out  1  marks the final pixel of the scan.
- `o_count`  out  32  pixels transferred in the current or last scan.
- `o_checksum`  out  32  sum mod 2**32 of transferred pixels.

## Operation
- Reset values: all outputs 0, FSM in IDLE, FIFO empty.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE + `start`:
  - latch `total = w*h` as a full 32-bit product; clear `o_count`, `o_checksum` and `o_err_size`.
  - If `total==0` or `total>2**AW`, set `o_err_size` and go to FIN. No reads are issued and `m_valid` is never asserted.
  - Otherwise go to RUN with read pointer 0.
- RUN: issue a read in a cycle when `fifo_occ + inflight + popped_this_cycle_adjust < 2`, i.e. when a free FIFO slot is guaranteed at capture.
  - Issuing a read drives `mem_raddr=ptr`, sets `inflight`, and increments `ptr`.
  - After the read of address `total-1` is issued, go to DRAIN.
- DRAIN: wait until the FIFO is empty and `inflight==0`, then go to FIN.
- FIN: registered `done=1` for one cycle; `busy` falls in the same cycle; return to IDLE.
- Read capture: in the cycle after an issue, `mem_rdata` is pushed into a 2-entry FIFO. The FIFO head drives `m_data` and `m_valid` from registers.
- `m_last` is 1 while the head entry is pixel index `total-1`.
- On each transfer, `o_count` increments by 1 and `o_checksum` adds the zero-extended `m_data`.
- `mem_raddr` holds its last value when no read is issued; reads have no side effects.
- `start` while busy is dropped with no effect.
- `rst_n` asserted mid-scan: immediate return to reset values; pixels in flight are discarded.

## Timing
- With `start` sampled at edge E0, the first `mem_raddr=0` is valid after E0. `m_valid` first rises after E2 (2-cycle start-to-data latency).
- With `m_ready` held high, throughput is 1 pixel/cycle with no bubbles after the first pixel.
- Stall rule: while `m_valid & ~m_ready`, `m_data` and `m_last` are stable. The FIFO never overflows and never drops data.
- `done` follows the final transfer (the one with `m_last`) by 1 cycle.
- The error path asserts `done` 1 cycle after the accepting edge.
- A `start` in the same cycle as `done` is ignored; a `start` one cycle later is accepted.

## Structure
- Shared package `dsa_pkg`: state enum `rd_state_e`, `PIX_W=8`, `CNT_W=32`.
- Sub-module `stream_skid_fifo`: 2-entry registered FIFO with push, pop and occupancy. The FSM, counters and checksum live in `out_stream_reader`.

## Test plan
- 4x4 scan, `m_ready=1`, memory `mem[a]=a`:
  - addresses 0..15 are issued in order and `m_data` sequence is 0..15;
  - `m_last` is set on the 16th pixel and `done` follows 1 cycle later;
  - `o_count=16`, `o_checksum=120`.
- 4x4 scan with `m_ready` pattern 1,0,0,1 repeating: same data order, no loss or duplication, outputs stable during stalls, `o_checksum=120`.
- Size errors:
  - `w=0,h=64` gives `o_err_size=1`, `done` 1 cycle after start, `m_valid` never high;
  - `w=65,h=64` (4160>4096) gives the same response.
- 64x64 full scan with every pixel 0xFF: 4096 transfers, last address 4095, `o_checksum=0x000FF000`, `o_count=4096`.
- `start` pulsed mid-scan is ignored and the scan completes unchanged. `rst_n` pulled low at pixel 7 clears `busy`, `m_valid` and the counters; a fresh `start` rescans from address 0.
